bcd_operand_entry: RTL and testbench



---
 rtl/bcd_operand_entry.sv | 171 +++++++++++++++++
 tb/tb_bcd_operand_entry.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_entry.sv
// Keypad front end for the BCD add/subtract ALU: builds signed 2-digit BCD operands and opcode, then shows the result.
// Optional build macro REPEAT_EQUALS_EN: '=' in SHOW repeats the last operation with op1 = previous result.
module bcd_operand_entry #(
  parameter int unsigned CALC_WAIT = 1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [8:0] result_in,
  input  logic       o_flag_in,
  output logic [8:0] op1,
  output logic [8:0] op2,
  output logic [2:0] opcode,
  output logic       calc_req,
  output logic       busy,
  output logic       err,
  output logic [8:0] display
);

  // Handshake: key_valid is a one-cycle strobe with no back-pressure; a key arriving
  // while it cannot be used (CALC, ERROR, full digit count) is simply dropped.
  typedef enum logic [2:0] {ENTER_OP1, ENTER_OP2, CALC, SHOW, ERROR} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(CALC_WAIT - 1);
  localparam logic [2:0] OPC_NONE  = 3'b000;
  localparam logic [2:0] OPC_ADD   = 3'b001;
  localparam logic [2:0] OPC_SUB   = 3'b010;

  state_t     state, state_n;
  logic [1:0] cnt1, cnt1_n, cnt2, cnt2_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  logic [8:0] op1_n, op2_n, res, res_n, display_n;
  logic [2:0] opcode_n, key_opcode;
  logic       calc_req_n;
  logic       is_digit, is_pm, is_eq, is_clr, is_neg;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_pm      = key_valid && ((key_code == 4'd10) || (key_code == 4'd11));
  assign is_eq      = key_valid && (key_code == 4'd12);
  assign is_clr     = key_valid && (key_code == 4'd13);
  assign is_neg     = key_valid && (key_code == 4'd14);
  assign key_opcode = (key_code == 4'd10) ? OPC_ADD : OPC_SUB;

  always_comb begin
    state_n    = state;
    op1_n      = op1;
    op2_n      = op2;
    cnt1_n     = cnt1;
    cnt2_n     = cnt2;
    opcode_n   = opcode;
    res_n      = res;
    wait_cnt_n = wait_cnt;
    calc_req_n = 1'b0;
    if (is_clr) begin
      state_n    = ENTER_OP1;
      op1_n      = '0;
      op2_n      = '0;
      cnt1_n     = '0;
      cnt2_n     = '0;
      opcode_n   = OPC_NONE;
      res_n      = '0;
      wait_cnt_n = '0;
    end else begin
      case (state)
        ENTER_OP1: begin
          if (is_digit && cnt1 != 2'd2) begin
            op1_n  = {op1[8], op1[3:0], key_code};
            cnt1_n = cnt1 + 2'd1;
          end else if (is_neg && op1[7:0] != 8'h00) begin
            op1_n[8] = ~op1[8];
          end else if (is_pm) begin
            opcode_n = key_opcode;
            op2_n    = '0;
            cnt2_n   = '0;
            state_n  = ENTER_OP2;
          end
        end
        ENTER_OP2: begin
          if (is_digit && cnt2 != 2'd2) begin
            op2_n  = {op2[8], op2[3:0], key_code};
            cnt2_n = cnt2 + 2'd1;
          end else if (is_neg && op2[7:0] != 8'h00) begin
            op2_n[8] = ~op2[8];
          end else if (is_pm && cnt2 == 2'd0) begin
            opcode_n = key_opcode;
          end else if (is_eq) begin
            // op2 is already zero when no digits were typed (negate never marks zero).
            state_n    = CALC;
            calc_req_n = 1'b1;
            wait_cnt_n = '0;
          end
        end
        CALC: begin
          if (wait_cnt == WAIT_LAST) begin
            res_n   = result_in;
            state_n = o_flag_in ? ERROR : SHOW;
          end else begin
            wait_cnt_n = wait_cnt + 4'd1;
          end
        end
        SHOW: begin
          if (is_digit) begin
            op1_n    = {5'b0, key_code};
            cnt1_n   = 2'd1;
            op2_n    = '0;
            cnt2_n   = '0;
            opcode_n = OPC_NONE;
            state_n  = ENTER_OP1;
          end else if (is_pm) begin
            op1_n    = res;
            cnt1_n   = 2'd2;
            opcode_n = key_opcode;
            op2_n    = '0;
            cnt2_n   = '0;
            state_n  = ENTER_OP2;
`ifdef REPEAT_EQUALS_EN
          end else if (is_eq) begin
            op1_n      = res;
            cnt1_n     = 2'd2;
            state_n    = CALC;
            calc_req_n = 1'b1;
            wait_cnt_n = '0;
`endif
          end
        end
        ERROR: ;
        default: state_n = ENTER_OP1;
      endcase
    end

    case (state_n)
      ENTER_OP1: display_n = op1_n;
      ENTER_OP2: display_n = (cnt2_n != 2'd0) ? op2_n : op1_n;
      CALC:      display_n = op2_n;
      SHOW:      display_n = res_n;
      default:   display_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= ENTER_OP1;
      op1      <= '0;
      op2      <= '0;
      cnt1     <= '0;
      cnt2     <= '0;
      opcode   <= OPC_NONE;
      res      <= '0;
      wait_cnt <= '0;
      calc_req <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      display  <= '0;
    end else begin
      state    <= state_n;
      op1      <= op1_n;
      op2      <= op2_n;
      cnt1     <= cnt1_n;
      cnt2     <= cnt2_n;
      opcode   <= opcode_n;
      res      <= res_n;
      wait_cnt <= wait_cnt_n;
      calc_req <= calc_req_n;
      busy     <= (state_n == CALC);
      err      <= (state_n == ERROR);
      display  <= display_n;
    end
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Bench for bcd_operand_entry: two instances (CALC_WAIT 1 and 4) share one key stream and are
// compared every cycle against a behavioural model; directed test-plan steps then random keys.
module tb_bcd_operand_entry;

  logic       clk = 1'b0;
  logic       nRst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [8:0] result_in;
  logic       o_flag_in;

  logic [8:0] op1_o[2], op2_o[2], display_o[2];
  logic [2:0] opcode_o[2];
  logic       calc_req_o[2], busy_o[2], err_o[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_operand_entry #(.CALC_WAIT(1)) dut_a (
    .clk(clk), .nRst(nRst), .key_valid(key_valid), .key_code(key_code),
    .result_in(result_in), .o_flag_in(o_flag_in),
    .op1(op1_o[0]), .op2(op2_o[0]), .opcode(opcode_o[0]), .calc_req(calc_req_o[0]),
    .busy(busy_o[0]), .err(err_o[0]), .display(display_o[0])
  );

  bcd_operand_entry #(.CALC_WAIT(4)) dut_b (
    .clk(clk), .nRst(nRst), .key_valid(key_valid), .key_code(key_code),
    .result_in(result_in), .o_flag_in(o_flag_in),
    .op1(op1_o[1]), .op2(op2_o[1]), .opcode(opcode_o[1]), .calc_req(calc_req_o[1]),
    .busy(busy_o[1]), .err(err_o[1]), .display(display_o[1])
  );

  // Reference model: one calculator per instance, mode numbers are local to the bench.
  localparam int M_OP1 = 0, M_OP2 = 1, M_CALC = 2, M_SHOW = 3, M_ERR = 4;
  int         wait_of[2] = '{1, 4};
  int         m_mode[2], m_n1[2], m_n2[2], m_left[2];
  logic [8:0] m_op1[2], m_op2[2], m_res[2];
  logic [2:0] m_opc[2];
  logic       m_req[2];

  function automatic logic [8:0] shift_digit(logic [8:0] v, logic [3:0] d);
    return {v[8], v[3:0], d};
  endfunction

  function automatic logic [8:0] flip_sign(logic [8:0] v);
    return (v[7:0] == 8'h00) ? v : {~v[8], v[7:0]};
  endfunction

  function automatic logic [8:0] m_display(int i);
    case (m_mode[i])
      M_OP1:   return m_op1[i];
      M_OP2:   return (m_n2[i] > 0) ? m_op2[i] : m_op1[i];
      M_CALC:  return m_op2[i];
      M_SHOW:  return m_res[i];
      default: return 9'h000;
    endcase
  endfunction

  task automatic model_reset(int i);
    m_mode[i] = M_OP1;
    m_n1[i] = 0; m_n2[i] = 0; m_left[i] = 0;
    m_op1[i] = '0; m_op2[i] = '0; m_res[i] = '0;
    m_opc[i] = 3'd0; m_req[i] = 1'b0;
  endtask

  task automatic model_step(int i, logic kv, logic [3:0] kc, logic [8:0] rin, logic fin);
    bit k   = kv && (kc != 4'd15);
    bit dig = k && (kc <= 4'd9);
    bit pm  = k && (kc == 4'd10 || kc == 4'd11);
    bit eq  = k && (kc == 4'd12);
    bit neg = k && (kc == 4'd14);
    logic [2:0] opc = (kc == 4'd10) ? 3'd1 : 3'd2;
    m_req[i] = 1'b0;
    if (k && kc == 4'd13) begin
      model_reset(i);
    end else begin
      case (m_mode[i])
        M_OP1: begin
          if (dig) begin
            if (m_n1[i] < 2) begin m_op1[i] = shift_digit(m_op1[i], kc); m_n1[i]++; end
          end else if (neg) m_op1[i] = flip_sign(m_op1[i]);
          else if (pm) begin
            m_opc[i] = opc; m_op2[i] = '0; m_n2[i] = 0; m_mode[i] = M_OP2;
          end
        end
        M_OP2: begin
          if (dig) begin
            if (m_n2[i] < 2) begin m_op2[i] = shift_digit(m_op2[i], kc); m_n2[i]++; end
          end else if (neg) m_op2[i] = flip_sign(m_op2[i]);
          else if (pm) begin
            if (m_n2[i] == 0) m_opc[i] = opc;
          end else if (eq) begin
            if (m_n2[i] == 0) m_op2[i] = '0;
            m_mode[i] = M_CALC; m_left[i] = wait_of[i]; m_req[i] = 1'b1;
          end
        end
        M_CALC: begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_res[i] = rin;
            m_mode[i] = fin ? M_ERR : M_SHOW;
          end
        end
        M_SHOW: begin
          if (dig) begin
            m_op1[i] = {5'b0, kc}; m_n1[i] = 1; m_op2[i] = '0; m_n2[i] = 0;
            m_opc[i] = 3'd0; m_mode[i] = M_OP1;
          end else if (pm) begin
            m_op1[i] = m_res[i]; m_n1[i] = 2; m_opc[i] = opc;
            m_op2[i] = '0; m_n2[i] = 0; m_mode[i] = M_OP2;
          end
`ifdef REPEAT_EQUALS_EN
          else if (eq) begin
            m_op1[i] = m_res[i]; m_n1[i] = 2;
            m_mode[i] = M_CALC; m_left[i] = wait_of[i]; m_req[i] = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.d%0d.op1", tag, i), op1_o[i], m_op1[i]);
      chk($sformatf("%s.d%0d.op2", tag, i), op2_o[i], m_op2[i]);
      chk($sformatf("%s.d%0d.opcode", tag, i), {6'b0, opcode_o[i]}, {6'b0, m_opc[i]});
      chk($sformatf("%s.d%0d.calc_req", tag, i), {8'b0, calc_req_o[i]}, {8'b0, m_req[i]});
      chk($sformatf("%s.d%0d.busy", tag, i), {8'b0, busy_o[i]}, {8'b0, m_mode[i] == M_CALC});
      chk($sformatf("%s.d%0d.err", tag, i), {8'b0, err_o[i]}, {8'b0, m_mode[i] == M_ERR});
      chk($sformatf("%s.d%0d.display", tag, i), display_o[i], m_display(i));
    end
  endtask

  // Apply one key (or idle) for one clock, advance the model on the edge, check at the falling edge.
  task automatic step(string tag, logic kv, logic [3:0] kc);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, kv, kc, result_in, o_flag_in);
    @(negedge clk);
    check_all(tag);
    key_valid = 1'b0;
  endtask

  task automatic key(string tag, logic [3:0] kc);
    step(tag, 1'b1, kc);
  endtask

  task automatic idle(string tag, int n);
    for (int c = 0; c < n; c++) step(tag, 1'b0, 4'd0);
  endtask

  initial begin
    nRst = 1'b0; key_valid = 1'b0; key_code = 4'd0; result_in = '0; o_flag_in = 1'b0;
    for (int i = 0; i < 2; i++) model_reset(i);
    #12;
    check_all("reset");
    chk("reset.display", display_o[0], 9'h000);
    @(negedge clk);
    nRst = 1'b1;
    idle("idle", 2);

    // Add path
    key("add", 4'd1); key("add", 4'd2); key("add", 4'd10); key("add", 4'd3); key("add", 4'd4);
    result_in = 9'h046;
    key("add.eq", 4'd12);
    chk("add.op1", op1_o[0], 9'h012);
    chk("add.op2", op2_o[0], 9'h034);
    chk("add.opcode", {6'b0, opcode_o[0]}, 9'h001);
    chk("add.calc_req_hi", {8'b0, calc_req_o[0]}, 9'h001);
    idle("add.wait", 1);
    chk("add.calc_req_lo", {8'b0, calc_req_o[0]}, 9'h000);
    chk("add.display", display_o[0], 9'h046);
    chk("add.busy", {8'b0, busy_o[0]}, 9'h000);
    idle("add.wait", 3);

    // Entry limits
    key("lim", 4'd13); key("lim", 4'd1); key("lim", 4'd2); key("lim", 4'd3);
    chk("lim.op1", op1_o[0], 9'h012);
    key("lim", 4'd14);
    chk("lim.neg", op1_o[0], 9'h112);
    key("lim", 4'd13); key("lim", 4'd14);
    chk("lim.negzero", op1_o[0], 9'h000);
    key("lim.rsvd", 4'd15);

    // Chaining
    key("chain", 4'd5); key("chain", 4'd11); key("chain", 4'd7);
    result_in = 9'h102;
    key("chain", 4'd12);
    idle("chain.wait", 4);
    chk("chain.display", display_o[1], 9'h102);
    key("chain", 4'd10); key("chain", 4'd3); key("chain", 4'd12);
    chk("chain.op1", op1_o[0], 9'h102);
    chk("chain.op2", op2_o[0], 9'h003);
    chk("chain.opcode", {6'b0, opcode_o[0]}, 9'h001);
    idle("chain.wait", 4);

    // Overflow
    key("ovf", 4'd13); key("ovf", 4'd1); key("ovf", 4'd10); key("ovf", 4'd2);
    o_flag_in = 1'b1;
    key("ovf", 4'd12);
    idle("ovf.wait", 4);
    chk("ovf.err", {8'b0, err_o[1]}, 9'h001);
    chk("ovf.display", display_o[1], 9'h000);
    key("ovf.dig", 4'd5); key("ovf.eq", 4'd12);
    o_flag_in = 1'b0;
    key("ovf.clr", 4'd13);
    chk("ovf.err_clr", {8'b0, err_o[0]}, 9'h000);
    chk("ovf.op1_clr", op1_o[0], 9'h000);
    key("ovf.after", 4'd9);
    chk("ovf.enter_op1", op1_o[0], 9'h009);

    // Asynchronous reset mid-entry
    key("arst", 4'd13); key("arst", 4'd4); key("arst", 4'd10); key("arst", 4'd6);
    #2 nRst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) model_reset(i);
    check_all("arst.async");
    chk("arst.op2", op2_o[0], 9'h000);
    @(negedge clk);
    nRst = 1'b1;
    check_all("arst.hold");

    // Clear in the second CALC cycle of the slow instance
    key("cclr", 4'd8); key("cclr", 4'd10); key("cclr", 4'd1);
    result_in = 9'h099;
    key("cclr", 4'd12);
    idle("cclr.c2", 1);
    key("cclr.clr", 4'd13);
    chk("cclr.busy", {8'b0, busy_o[1]}, 9'h000);
    idle("cclr.after", 4);
    chk("cclr.display", display_o[1], 9'h000);

    // Repeat equals
    key("rep", 4'd1); key("rep", 4'd10); key("rep", 4'd2);
    result_in = 9'h003;
    key("rep", 4'd12);
    idle("rep.wait", 4);
    key("rep.eq2", 4'd12);
`ifdef REPEAT_EQUALS_EN
    chk("rep.op1", op1_o[0], 9'h003);
    chk("rep.calc_req", {8'b0, calc_req_o[0]}, 9'h001);
`else
    chk("rep.op1", op1_o[0], 9'h001);
    chk("rep.calc_req", {8'b0, calc_req_o[0]}, 9'h000);
    chk("rep.display", display_o[0], 9'h003);
`endif
    chk("rep.op2", op2_o[0], 9'h002);
    chk("rep.opcode", {6'b0, opcode_o[0]}, 9'h001);
    idle("rep.wait", 4);

    // Random key streams
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0)
        result_in = 9'($urandom_range(0, 511));
      else
        result_in = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      o_flag_in = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) begin
        step("rand", 1'b0, 4'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 1) == 0) begin
        step("rand", 1'b1, 4'($urandom_range(0, 9)));
      end else begin
        step("rand", 1'b1, 4'($urandom_range(10, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
